// File: rtl/packer_nxw.sv
// packer_nxw: collects RATIO words of IN_W bits into one wide word with a one-cycle strobe.
// Optional feature macro PACKER_FLUSH_EN adds a flush input that emits a partially filled word.
module packer_nxw #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                       clk_4f,
  input  logic                       reset_L,
  input  logic [IN_W-1:0]            data_in,
  input  logic                       valid_in,
`ifdef PACKER_FLUSH_EN
  input  logic                       flush,
`endif
  output logic [IN_W*RATIO-1:0]      data_out,
  output logic                       valid_out,
  output logic [$clog2(RATIO+1)-1:0] lanes_out
);

  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned LANE_W = $clog2(RATIO);
  localparam int unsigned CNT_W  = $clog2(RATIO + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [OUT_W-1:0]  asm_q, asm_d;
  logic [OUT_W-1:0]  data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic [CNT_W-1:0]  lanes_out_q, lanes_out_d;

  logic [LANE_W-1:0] lane_idx_c;
  logic [OUT_W-1:0]  merged_c;
  logic              complete_c;
  logic              flush_c;

  // Assembly register with the current word dropped into its lane
  always_comb begin
    lane_idx_c = (MSB_FIRST != 0) ? (LAST_LANE - lane_q) : lane_q;
    merged_c   = asm_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (valid_in && (lane_idx_c == LANE_W'(k))) begin
        merged_c[k*IN_W +: IN_W] = data_in;
      end
    end
  end

  assign complete_c = valid_in && (lane_q == LAST_LANE);

`ifdef PACKER_FLUSH_EN
  assign flush_c = flush && ((lane_q != '0) || valid_in);
`else
  assign flush_c = 1'b0;
`endif

  // Next state: a completion wins over flush so lanes_out reports a full word
  always_comb begin
    lane_d      = lane_q;
    asm_d       = asm_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    lanes_out_d = lanes_out_q;
    if (complete_c || flush_c) begin
      data_out_d  = merged_c;
      valid_out_d = 1'b1;
      lanes_out_d = complete_c ? CNT_W'(RATIO)
                               : (CNT_W'(lane_q) + CNT_W'(valid_in));
      lane_d      = '0;
      asm_d       = '0;
    end else if (valid_in) begin
      asm_d  = merged_c;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      lane_q      <= '0;
      asm_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      lanes_out_q <= '0;
    end else begin
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      lanes_out_q <= lanes_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lanes_out = lanes_out_q;

endmodule

// File: tb/tb_packer_nxw.sv
// tb_packer_nxw: scoreboard bench for packer_nxw in MSB-first, LSB-first and RATIO=3 builds.
module tb_packer_nxw;

  localparam int unsigned W  = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned W3 = 4;
  localparam int unsigned R3 = 3;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  lanes;
  } exp_t;

  logic clk_4f = 1'b0;
  logic reset_L;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic [W3-1:0] data_in3;
  logic          valid_in3;
`ifdef PACKER_FLUSH_EN
  logic flush;
  logic flush3;
`endif

  logic [W*R-1:0]   dout_a, dout_b;
  logic             vout_a, vout_b;
  logic [2:0]       lanes_a, lanes_b;
  logic [W3*R3-1:0] dout_3;
  logic             vout_3;
  logic [1:0]       lanes_3;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;

  exp_t q_a[$], q_b[$], q_3[$];
  int unsigned strobe_cyc_a[$];
  exp_t e_a, e_b, e_3;

  // Bench-side model of the words collected so far
  int unsigned n_ab;
  logic [31:0] msb_acc, lsb_acc;
  int unsigned n_3;
  logic [31:0] acc_3;

  always #5 clk_4f = ~clk_4f;
  always @(posedge clk_4f) cyc++;

  packer_nxw #(.IN_W(W), .RATIO(R), .MSB_FIRST(1)) u_dut (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
`ifdef PACKER_FLUSH_EN
    .flush(flush),
`endif
    .data_out(dout_a), .valid_out(vout_a), .lanes_out(lanes_a));

  packer_nxw #(.IN_W(W), .RATIO(R), .MSB_FIRST(0)) u_lsb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
`ifdef PACKER_FLUSH_EN
    .flush(flush),
`endif
    .data_out(dout_b), .valid_out(vout_b), .lanes_out(lanes_b));

  packer_nxw #(.IN_W(W3), .RATIO(R3), .MSB_FIRST(1)) u_r3 (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in3), .valid_in(valid_in3),
`ifdef PACKER_FLUSH_EN
    .flush(flush3),
`endif
    .data_out(dout_3), .valid_out(vout_3), .lanes_out(lanes_3));

  // Scoreboard monitors: every strobe must match the oldest pending expectation
  always @(negedge clk_4f) begin
    if (vout_a === 1'b1) begin
      vectors++;
      strobe_cyc_a.push_back(cyc);
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL strobe_a unexpected: data_out=%h lanes=%0d, required no strobe", dout_a, lanes_a);
      end else begin
        e_a = q_a.pop_front();
        if (dout_a !== e_a.data || lanes_a !== e_a.lanes) begin
          errors++;
          $display("FAIL word_a: got %h/%0d, required %h/%0d", dout_a, lanes_a, e_a.data, e_a.lanes);
        end
      end
    end
  end

  always @(negedge clk_4f) begin
    if (vout_b === 1'b1) begin
      vectors++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL strobe_b unexpected: data_out=%h lanes=%0d, required no strobe", dout_b, lanes_b);
      end else begin
        e_b = q_b.pop_front();
        if (dout_b !== e_b.data || lanes_b !== e_b.lanes) begin
          errors++;
          $display("FAIL word_b: got %h/%0d, required %h/%0d", dout_b, lanes_b, e_b.data, e_b.lanes);
        end
      end
    end
  end

  always @(negedge clk_4f) begin
    if (vout_3 === 1'b1) begin
      vectors++;
      if (q_3.size() == 0) begin
        errors++;
        $display("FAIL strobe_3 unexpected: data_out=%h lanes=%0d, required no strobe", dout_3, lanes_3);
      end else begin
        e_3 = q_3.pop_front();
        if (32'(dout_3) !== e_3.data || 3'(lanes_3) !== e_3.lanes) begin
          errors++;
          $display("FAIL word_3: got %h/%0d, required %h/%0d", dout_3, lanes_3, e_3.data, e_3.lanes);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    n_ab = 0; msb_acc = '0; lsb_acc = '0;
    n_3 = 0; acc_3 = '0;
  endtask

  task automatic send_ab(input logic [W-1:0] w);
    @(negedge clk_4f);
    data_in  = w;
    valid_in = 1'b1;
    msb_acc  = (msb_acc << W) | 32'(w);
    lsb_acc  = lsb_acc | (32'(w) << (n_ab * W));
    n_ab++;
    if (n_ab == R) begin
      q_a.push_back('{data: msb_acc, lanes: 3'(R)});
      q_b.push_back('{data: lsb_acc, lanes: 3'(R)});
      n_ab = 0; msb_acc = '0; lsb_acc = '0;
    end
  endtask

  task automatic send_3(input logic [W3-1:0] w);
    @(negedge clk_4f);
    data_in3  = w;
    valid_in3 = 1'b1;
    acc_3 = (acc_3 << W3) | 32'(w);
    n_3++;
    if (n_3 == R3) begin
      q_3.push_back('{data: acc_3, lanes: 3'(R3)});
      n_3 = 0; acc_3 = '0;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk_4f);
      valid_in  = 1'b0;
      valid_in3 = 1'b0;
      data_in   = W'($urandom);
      data_in3  = W3'($urandom);
    end
  endtask

  // Bounded wait for every pending expectation to be consumed
  task automatic drain();
    int unsigned budget;
    budget = 0;
    idle(1);
    while ((q_a.size() + q_b.size() + q_3.size()) != 0 && budget < 20) begin
      idle(1);
      budget++;
    end
    idle(2);
    vectors++;
    if ((q_a.size() + q_b.size() + q_3.size()) != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d r3=%0d, required 0", q_a.size(), q_b.size(), q_3.size());
      q_a.delete(); q_b.delete(); q_3.delete();
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    data_in = '0; valid_in = 1'b0; data_in3 = '0; valid_in3 = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush = 1'b0; flush3 = 1'b0;
`endif
    model_clear();
    repeat (3) @(negedge clk_4f);
    vectors++;
    if (dout_a !== '0 || vout_a !== 1'b0 || lanes_a !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h/%b/%0d, required 0/0/0", dout_a, vout_a, lanes_a);
    end
    vectors++;
    if (dout_b !== '0 || vout_b !== 1'b0 || lanes_b !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h/%b/%0d, required 0/0/0", dout_b, vout_b, lanes_b);
    end
    vectors++;
    if (dout_3 !== '0 || vout_3 !== 1'b0 || lanes_3 !== '0) begin
      errors++;
      $display("FAIL reset_3: got %h/%b/%0d, required 0/0/0", dout_3, vout_3, lanes_3);
    end
    reset_L = 1'b1;
  endtask

  task automatic test_continuous();
    logic [W-1:0] words [8];
    int diff;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    strobe_cyc_a.delete();
    for (int i = 0; i < 8; i++) send_ab(words[i]);
    drain();
    diff = (strobe_cyc_a.size() == 2) ? int'(strobe_cyc_a[1] - strobe_cyc_a[0]) : -1;
    vectors++;
    if (diff != 4) begin
      errors++;
      $display("FAIL back_to_back_spacing: strobes=%0d spacing=%0d, required 2 strobes 4 apart",
               strobe_cyc_a.size(), diff);
    end
    vectors++;
    if (dout_a !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL hold_a: got %h, required aabbccdd", dout_a);
    end
  endtask

  task automatic test_gapped();
    strobe_cyc_a.delete();
    for (int i = 1; i <= 4; i++) begin
      send_ab(W'(i));
      if (i < 4) begin
        for (int g = 0; g < 2; g++) begin
          idle(1);
          vectors++;
          if (vout_a !== 1'b0 || vout_b !== 1'b0) begin
            errors++;
            $display("FAIL gap_strobe: valid_out a=%b b=%b, required 0", vout_a, vout_b);
          end
        end
      end
    end
    drain();
    vectors++;
    if (strobe_cyc_a.size() != 1) begin
      errors++;
      $display("FAIL gapped_count: got %0d strobes, required 1", strobe_cyc_a.size());
    end
  endtask

  task automatic test_ratio3();
    logic [W3-1:0] nib [6];
    nib = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 6; i++) begin
      send_3(nib[i]);
      vectors++;
      if (u_r3.lane_q > 2'd2) begin
        errors++;
        $display("FAIL r3_lane_range: lane=%0d, required <= 2", u_r3.lane_q);
      end
    end
    drain();
    vectors++;
    if (dout_3 !== 12'hDEF || lanes_3 !== 2'd3) begin
      errors++;
      $display("FAIL r3_hold: got %h/%0d, required def/3", dout_3, lanes_3);
    end
  endtask

  task automatic test_partial_persist();
    send_ab(8'h12);
    send_ab(8'h34);
    idle(10);
    send_ab(8'h56);
    send_ab(8'h78);
    drain();
  endtask

  task automatic test_reset_mid();
    send_ab(8'h55);
    send_ab(8'h66);
    send_3(4'h7);
    @(posedge clk_4f);
    #2;
    reset_L   = 1'b0;
    valid_in  = 1'b0;
    valid_in3 = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dout_a !== '0 || vout_a !== 1'b0 || lanes_a !== '0 || dout_b !== '0 || dout_3 !== '0) begin
      errors++;
      $display("FAIL async_reset: got a=%h/%b/%0d b=%h r3=%h, required all 0",
               dout_a, vout_a, lanes_a, dout_b, dout_3);
    end
    repeat (2) begin
      @(negedge clk_4f);
      vectors++;
      if (vout_a !== 1'b0 || dout_a !== '0) begin
        errors++;
        $display("FAIL in_reset: got %h/%b, required 0/0", dout_a, vout_a);
      end
    end
    reset_L = 1'b1;
    for (int i = 1; i <= 4; i++) send_ab(W'(i));
    for (int i = 1; i <= 3; i++) send_3(W3'(i));
    drain();
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic flush_ab(input bit with_word, input logic [W-1:0] w);
    @(negedge clk_4f);
    flush    = 1'b1;
    valid_in = with_word;
    data_in  = w;
    if (with_word) begin
      msb_acc = (msb_acc << W) | 32'(w);
      lsb_acc = lsb_acc | (32'(w) << (n_ab * W));
      n_ab++;
    end
    if (n_ab != 0) begin
      q_a.push_back('{data: msb_acc << ((R - n_ab) * W), lanes: 3'(n_ab)});
      q_b.push_back('{data: lsb_acc, lanes: 3'(n_ab)});
    end
    n_ab = 0; msb_acc = '0; lsb_acc = '0;
    @(negedge clk_4f);
    flush    = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic test_flush();
    send_ab(8'h12);
    send_ab(8'h34);
    flush_ab(1'b0, 8'h00);
    drain();
    flush_ab(1'b0, 8'h00);
    drain();
    send_ab(8'h12);
    send_ab(8'h34);
    flush_ab(1'b1, 8'h56);
    drain();
    send_ab(8'h01);
    send_ab(8'h02);
    send_ab(8'h03);
    flush_ab(1'b1, 8'h04);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_ratio3();
    test_partial_persist();
    test_reset_mid();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
